calculadora_ctrl: RTL
=====================

CALCULADORA_CTRL -- requirements
Module: calculadora_ctrl

Interface
REQ-001 Parameter: DEB_CYCLES, default 4, consecutive stable cycles required to qualify a button level (used only with CTRL_DEBOUNCE_EN).
REQ-002 Parameter: HOLDOFF, default 2, cycles spent in HOLD after each issued command; legal range 1..15.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 btn_zerar, btn_somar, btn_subtrair, btn_mostrar  input  1 each  raw active-high button levels.
REQ-006 sw_entrada  input  10  switch value to load into the calculator.
REQ-007 zerar, somar, subtrair, mostrar  output  1 each  single-cycle command pulses to the calculator datapath.
REQ-008 entrada  output  10  registered operand presented to the calculator.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 last_op  output  2  code of last issued command: 0 zerar, 1 somar, 2 subtrair, 3 mostrar.
REQ-011 op_count  output  8  count of issued commands, wraps 255->0.

Function
REQ-012 FSM states SHALL be IDLE, ISSUE, HOLD, WAIT_RELEASE.
REQ-013 IDLE: if any qualified button is high at a clock edge, the block SHALL select one command by fixed priority zerar > somar > subtrair > mostrar and move to ISSUE.
REQ-014 On the same edge as selecting mostrar, entrada SHALL load sw_entrada; entrada SHALL hold its value at all other times.
REQ-015 ISSUE: exactly the selected output SHALL be high for exactly one cycle; last_op SHALL update and op_count SHALL increment on the edge leaving ISSUE; next state HOLD.
REQ-016 Latency: button qualified high at edge N -> command pulse high during cycle N+1 to N+2.
REQ-017 HOLD SHALL last exactly HOLDOFF cycles, ignoring all buttons, then go to WAIT_RELEASE.
REQ-018 WAIT_RELEASE SHALL return to IDLE only on an edge where all four qualified buttons are low; a held button SHALL never produce a second command.
REQ-019 Simultaneous presses SHALL yield only the highest-priority command; lower-priority buttons SHALL not be queued.
REQ-020 At most one command output SHALL be high in any cycle; all command outputs SHALL be low outside ISSUE.
REQ-021 sw_entrada changes while not selecting mostrar SHALL not affect entrada.

Reset
REQ-022 reset high at a clock edge SHALL force state IDLE, all command outputs 0, entrada 0, busy 0, last_op 0, op_count 0, and clear debounce counters and qualified levels to 0.
REQ-023 reset asserted during ISSUE SHALL suppress the pulse from the next cycle onward; no partial command SHALL be issued after reset.
REQ-024 A button held high through reset release SHALL be accepted in IDLE on the first qualifying edge after reset deasserts.

Configuration
REQ-025 Macro CTRL_DEBOUNCE_EN defined: each button's qualified level SHALL change only after the raw level has differed from it for DEB_CYCLES consecutive cycles; a shorter glitch SHALL reset that button's counter and be ignored; this applies to both press and release.
REQ-026 Macro CTRL_DEBOUNCE_EN undefined: qualified level SHALL equal the raw input directly, no counters synthesized, and REQ-016 latency applies from the raw input.

Verification
REQ-027 No macro: reset 10 cycles, sw_entrada=10, btn_mostrar high 1 cycle -> mostrar pulses exactly one cycle, entrada=10, last_op=3, op_count=1.
REQ-028 No macro: btn_somar held 20 cycles -> exactly one somar pulse; busy stays high until the cycle after release; op_count increments by 1.
REQ-029 No macro: btn_zerar and btn_subtrair raised on same edge -> only zerar pulses, subtrair never pulses, last_op=0.
REQ-030 No macro: second press during HOLD (HOLDOFF=2) then release -> ignored, no second pulse; fresh press after IDLE -> pulse issued.
REQ-031 CTRL_DEBOUNCE_EN, DEB_CYCLES=4: btn_subtrair high 3 cycles -> no pulse; high 4 cycles -> one subtrair pulse one cycle after qualification.
REQ-032 reset asserted on the cycle entering ISSUE for somar -> somar low from the next cycle, op_count=0, state IDLE; 256 commands issued -> op_count wraps to 0.

Source files
------------

// File: rtl/calculadora_ctrl.sv
// Button-to-command controller for the calculator datapath: picks one command per press,
// pulses it for one cycle, then ignores buttons until released. Optional debounce: CTRL_DEBOUNCE_EN.
module calculadora_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int HOLDOFF    = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_zerar,
  input  logic       btn_somar,
  input  logic       btn_subtrair,
  input  logic       btn_mostrar,
  input  logic [9:0] sw_entrada,
  output logic       zerar,
  output logic       somar,
  output logic       subtrair,
  output logic       mostrar,
  output logic [9:0] entrada,
  output logic       busy,
  output logic [1:0] last_op,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, WAIT_RELEASE} state_t;

  state_t     r_state;
  logic [3:0] r_hold_cnt;
  logic [1:0] r_sel;
  logic [3:0] w_btn_raw;
  logic [3:0] w_btn_q;
  logic [1:0] w_pick;

  // Bit order matches the command code: 0 zerar, 1 somar, 2 subtrair, 3 mostrar.
  assign w_btn_raw = {btn_mostrar, btn_subtrair, btn_somar, btn_zerar};

`ifdef CTRL_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [3:0]         r_btn_q;
  logic [3:0][CW-1:0] r_deb_cnt;

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_btn_q   <= '0;
      r_deb_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (w_btn_raw[i] != r_btn_q[i]) begin
          if (r_deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
            r_btn_q[i]   <= w_btn_raw[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_btn_q = r_btn_q;
`else
  assign w_btn_q = w_btn_raw;
`endif

  always_comb begin
    w_pick = 2'd3;
    if (w_btn_q[0])      w_pick = 2'd0;
    else if (w_btn_q[1]) w_pick = 2'd1;
    else if (w_btn_q[2]) w_pick = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
      r_sel      <= '0;
      zerar      <= 1'b0;
      somar      <= 1'b0;
      subtrair   <= 1'b0;
      mostrar    <= 1'b0;
      entrada    <= '0;
      busy       <= 1'b0;
      last_op    <= '0;
      op_count   <= '0;
    end else begin
      zerar    <= 1'b0;
      somar    <= 1'b0;
      subtrair <= 1'b0;
      mostrar  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|w_btn_q) begin
            // Pulse is registered here so it is high exactly while in ISSUE.
            r_state  <= ISSUE;
            busy     <= 1'b1;
            r_sel    <= w_pick;
            zerar    <= (w_pick == 2'd0);
            somar    <= (w_pick == 2'd1);
            subtrair <= (w_pick == 2'd2);
            mostrar  <= (w_pick == 2'd3);
            if (w_pick == 2'd3) entrada <= sw_entrada;
          end
        end
        ISSUE: begin
          last_op    <= r_sel;
          op_count   <= op_count + 8'd1;
          r_hold_cnt <= 4'(HOLDOFF - 1);
          r_state    <= HOLD;
        end
        HOLD: begin
          if (r_hold_cnt == 4'd0) r_state <= WAIT_RELEASE;
          else                    r_hold_cnt <= r_hold_cnt - 4'd1;
        end
        WAIT_RELEASE: begin
          if (w_btn_q == 4'd0) begin
            r_state <= IDLE;
            busy    <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
